// File: rtl/gfx_fb_reader.sv
// gfx_fb_reader: fetches one framebuffer frame over an AXI-style read
// channel in raster order and emits it as a gfx pixel stream.
module gfx_fb_reader #(
    parameter int FB_WIDTH       = 640,
    parameter int FB_HEIGHT      = 480,
    parameter int PIXEL_BITS     = 12,
    parameter int AXI_ADDR_WIDTH = 20,
    parameter int AXI_DATA_WIDTH = 16,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic [AXI_ADDR_WIDTH-1:0]    axi_araddr,
    output logic                         axi_arvalid,
    input  logic                         axi_arready,
    input  logic [AXI_DATA_WIDTH-1:0]    axi_rdata,
    input  logic                         axi_rvalid,
    output logic                         axi_rready,
    output logic                         pvalid,
    input  logic                         pready,
    output logic [$clog2(FB_WIDTH)-1:0]  x,
    output logic [$clog2(FB_HEIGHT)-1:0] y,
    output logic [PIXEL_BITS-1:0]        color,
    output logic                         last
);

    localparam int XW  = $clog2(FB_WIDTH);
    localparam int YW  = $clog2(FB_HEIGHT);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;
    localparam int CRW = CW + 1;

    localparam logic [XW-1:0] X_MAX = XW'(FB_WIDTH - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(FB_HEIGHT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]                state_q, state_d;
    logic                      done_q, done_d;
    logic [XW-1:0]             ar_x_q, ar_x_d;
    logic [YW-1:0]             ar_y_q, ar_y_d;
    logic [AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [CW-1:0]             inflight_q, inflight_d;
    logic [CW-1:0]             count_q, count_d;
    logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
    logic [XW-1:0]             ox_q, ox_d;
    logic [YW-1:0]             oy_q, oy_d;
    logic [PIXEL_BITS-1:0]     mem [FIFO_DEPTH];

    logic [CRW-1:0] credit;
    logic           ar_acc;
    logic           push;
    logic           pop;
    logic           ar_end;
    logic           pix_last;
    logic           fifo_nempty;

    // Only the low PIXEL_BITS of each read beat carry color.
    generate
        if (AXI_DATA_WIDTH > PIXEL_BITS) begin : g_unused
            logic unused_rdata;
            assign unused_rdata = ^axi_rdata[AXI_DATA_WIDTH-1:PIXEL_BITS];
        end
    endgenerate

    // Handshake qualifiers; reads in flight plus buffered pixels never exceed the FIFO.
    always_comb begin
        credit      = CRW'(inflight_q) + CRW'(count_q);
        busy        = (state_q != S_IDLE);
        axi_arvalid = (state_q == S_ISSUE) && (credit < CRW'(FIFO_DEPTH));
        ar_acc      = axi_arvalid && axi_arready;
        axi_rready  = busy;
        push        = busy && axi_rvalid;
        fifo_nempty = (count_q != '0);
        pop         = fifo_nempty && pready;
        ar_end      = (ar_x_q == X_MAX) && (ar_y_q == Y_MAX);
        pix_last    = (ox_q == X_MAX) && (oy_q == Y_MAX);
        axi_araddr  = araddr_q;
        pvalid      = fifo_nempty;
        color       = fifo_nempty ? mem[rd_ptr_q] : '0;
        last        = fifo_nempty && pix_last;
        x           = ox_q;
        y           = oy_q;
        done        = done_q;
    end

    // Frame control, read-address counter, pixel counter and FIFO bookkeeping.
    always_comb begin
        state_d    = state_q;
        done_d     = 1'b0;
        ar_x_d     = ar_x_q;
        ar_y_d     = ar_y_q;
        araddr_d   = araddr_q;
        ox_d       = ox_q;
        oy_d       = oy_q;
        inflight_d = inflight_q + CW'(ar_acc) - CW'(push);
        count_d    = count_q + CW'(push) - CW'(pop);
        wr_ptr_d   = wr_ptr_q + PW'(push);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_ISSUE;
                    ar_x_d   = '0;
                    ar_y_d   = '0;
                    araddr_d = '0;
                    ox_d     = '0;
                    oy_d     = '0;
                end
            end
            S_ISSUE: begin
                if (ar_acc) begin
                    araddr_d = araddr_q + AXI_ADDR_WIDTH'(1);
                    if (ar_end) begin
                        state_d = S_DRAIN;
                    end else if (ar_x_q == X_MAX) begin
                        ar_x_d = '0;
                        ar_y_d = ar_y_q + YW'(1);
                    end else begin
                        ar_x_d = ar_x_q + XW'(1);
                    end
                end
            end
            default: ;
        endcase
        if (pop) begin
            if (pix_last) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end else if (ox_q == X_MAX) begin
                ox_d = '0;
                oy_d = oy_q + YW'(1);
            end else begin
                ox_d = ox_q + XW'(1);
            end
        end
    end

    // Control and counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            done_q     <= 1'b0;
            ar_x_q     <= '0;
            ar_y_q     <= '0;
            araddr_q   <= '0;
            inflight_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ox_q       <= '0;
            oy_q       <= '0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            ar_x_q     <= ar_x_d;
            ar_y_q     <= ar_y_d;
            araddr_q   <= araddr_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ox_q       <= ox_d;
            oy_q       <= oy_d;
        end
    end

    // Pixel storage; contents are only visible through the occupancy count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= axi_rdata[PIXEL_BITS-1:0];
        end
    end

    // The credit scheme must make a push into a full FIFO impossible.
    always_ff @(posedge clk) begin
        if (reset_n && push && !pop) begin
            assert (count_q != CW'(FIFO_DEPTH));
        end
    end

endmodule
